mem_access_unit: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_timeout_ctr.sv | 41 ++++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg: shared state encoding and MEM-control bit indices. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam int MEM_LD          = 0;
  localparam int MEM_ST          = 1;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ---------------------------------------------------------------------------
// mem_timeout_ctr: clear/enable counter, o_tc at TIMEOUT-1; TIMEOUT=0 never expires. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  // Saturates at terminal count so a held enable cannot wrap past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_never
      assign o_tc = 1'b0;
    end else begin : g_expire
      assign o_tc = (r_cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit: MEM-stage load/store req/ack controller with timeout.
// Optional misalignment abort via MEM_ALIGN_CHECK_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
  import mem_stage_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic [3:0]    z_in,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] wdata_in,
  input  logic [1:0]    mem_ctl_in,
  input  logic [3:0]    wb_ctl_in,
  output logic [DW-1:0] alu_out,
  output logic [DW-1:0] mem_out,
  output logic [3:0]    z_out,
  output logic [3:0]    wb_ctl_out,
  output logic          stall_out,
  output logic          err_out,
  output logic          misalign_out,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic          dm_ack,
  input  logic [DW-1:0] dm_rdata
);

  mem_state_t    r_state;
  logic          r_dm_req;
  logic          r_dm_we;
  logic          r_err;
  logic          r_misalign;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  logic          w_op;
  logic          w_store;
  logic          w_misalign;
  logic          w_clr;
  logic          w_cnt_en;
  logic          w_tc;

  assign w_op    = mem_ctl_in[MEM_LD] | mem_ctl_in[MEM_ST];
  assign w_store = mem_ctl_in[MEM_ST];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = (addr_in[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_clr    = (r_state == IDLE) && w_op;
  assign w_cnt_en = (r_state == REQ) && !dm_ack;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_op) begin
            r_addr  <= addr_in;
            r_wdata <= wdata_in;
            if (w_misalign) begin
              r_misalign <= 1'b1;
              r_rdata    <= '0;
              r_state    <= DONE;
            end else begin
              r_dm_req <= 1'b1;
              r_dm_we  <= w_store;
              r_state  <= REQ;
            end
          end
        end
        REQ: begin
          // An ack on the terminal-count cycle still completes normally.
          if (dm_ack) begin
            r_rdata  <= r_dm_we ? '0 : dm_rdata;
            r_dm_req <= 1'b0;
            r_dm_we  <= 1'b0;
            r_state  <= DONE;
          end else if (w_tc) begin
            r_err    <= 1'b1;
            r_rdata  <= '0;
            r_dm_req <= 1'b0;
            r_dm_we  <= 1'b0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (adv) begin
            r_err      <= 1'b0;
            r_misalign <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_out      = addr_in;
  assign z_out        = z_in;
  assign wb_ctl_out   = wb_ctl_in;
  assign mem_out      = (r_state == DONE) ? r_rdata : '0;
  assign stall_out    = !rst && (((r_state == IDLE) && w_op) || (r_state == REQ));
  assign err_out      = r_err;
  assign misalign_out = r_misalign;
  assign dm_req       = r_dm_req;
  assign dm_we        = r_dm_we;
  assign dm_addr      = r_addr;
  assign dm_wdata     = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit: directed + randomized bench for mem_access_unit. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

  localparam int TO = 6;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adv = 1'b0;
  logic [3:0]  z_in = '0;
  logic [31:0] addr_in = '0;
  logic [31:0] wdata_in = '0;
  logic [1:0]  mem_ctl_in = '0;
  logic [3:0]  wb_ctl_in = '0;
  logic [31:0] alu_out, mem_out, dm_addr, dm_wdata;
  logic [3:0]  z_out, wb_ctl_out;
  logic        stall_out, err_out, misalign_out, dm_req, dm_we;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_unit #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .adv(adv), .z_in(z_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .mem_ctl_in(mem_ctl_in), .wb_ctl_in(wb_ctl_in),
    .alu_out(alu_out), .mem_out(mem_out), .z_out(z_out), .wb_ctl_out(wb_ctl_out),
    .stall_out(stall_out), .err_out(err_out), .misalign_out(misalign_out),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with the unit idle; returns at posedge+1 after adv retires it.
  task automatic run_op(input logic [1:0] ctl, input logic [31:0] addr, input logic [31:0] wd,
                        input int d, input logic [31:0] rdata, input int hold);
    bit          st      = ctl[1];
    bit          mis     = ALIGN_EN && (addr[1:0] != 2'b00);
    bit          tmo     = !mis && (TO != 0) && (d > TO);
    int          exp_req = mis ? 0 : (tmo ? TO : d);
    logic [31:0] exp_mem = (mis || tmo || st) ? 32'h0 : rdata;
    logic [3:0]  zz      = 4'($urandom);
    logic [3:0]  wb      = 4'($urandom);
    int          nreq    = 0;
    int          nstall  = 0;
    bit          done    = 1'b0;

    mem_ctl_in = ctl; addr_in = addr; wdata_in = wd; z_in = zz; wb_ctl_in = wb;
    dm_ack = 1'b0; adv = 1'($urandom);
    @(negedge clk);
    chk("idle_stall", stall_out, 1);
    chk("idle_req", dm_req, 0);
    chk("pass_alu", alu_out, addr);
    chk("pass_z", z_out, zz);
    chk("pass_wb", wb_ctl_out, wb);
    if (stall_out) nstall++;

    for (int c = 1; c <= TO + 4 && !done; c++) begin
      @(posedge clk); #1;
      adv      = 1'b0;
      dm_ack   = (c == d);
      dm_rdata = (c == d) ? rdata : $urandom;
      @(negedge clk);
      if (dm_req) begin
        nreq++;
        if (stall_out) nstall++;
        chk("req_addr", dm_addr, addr);
        chk("req_we", dm_we, st);
        if (st) chk("req_wdata", dm_wdata, wd);
      end else begin
        done = 1'b1;
      end
    end
    chk("done_reached", done, 1);
    chk("req_cycles", nreq, exp_req);
    chk("stall_cycles", nstall, 1 + exp_req);
    chk("done_stall", stall_out, 0);
    chk("done_mem", mem_out, exp_mem);
    chk("done_err", err_out, tmo);
    chk("done_misalign", misalign_out, mis);

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      dm_ack = 1'($urandom); dm_rdata = $urandom; adv = 1'b0;
      @(negedge clk);
      chk("hold_req", dm_req, 0);
      chk("hold_mem", mem_out, exp_mem);
      chk("hold_err", err_out, tmo);
      chk("hold_stall", stall_out, 0);
    end
    @(posedge clk); #1;
    dm_ack = 1'b0; adv = 1'b1;
    @(negedge clk);
    chk("adv_mem", mem_out, exp_mem);
    @(posedge clk); #1;
    adv = 1'b0;
  endtask

  task automatic idle_cycle();
    mem_ctl_in = 2'b00; addr_in = $urandom; dm_ack = 1'($urandom); adv = 1'($urandom);
    @(negedge clk);
    chk("nop_stall", stall_out, 0);
    chk("nop_req", dm_req, 0);
    chk("nop_mem", mem_out, 0);
    chk("nop_err", err_out, 0);
    chk("nop_misalign", misalign_out, 0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_req", dm_req, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_misalign", misalign_out, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_mem", mem_out, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Load with ack in first REQ cycle.
    run_op(2'b01, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0);
    // Store acked on fifth REQ cycle, held in DONE three cycles.
    run_op(2'b10, 32'h40, 32'h12345678, 5, 32'hCAFEF00D, 3);
    idle_cycle();
    // Both control bits set behaves as a store.
    run_op(2'b11, 32'h80, 32'hA5A5A5A5, 2, 32'h11111111, 1);
    // Timeout: never acked.
    run_op(2'b01, 32'h200, 32'h0, 1000, 32'h22222222, 1);
    // Ack on the terminal-count cycle still completes.
    run_op(2'b01, 32'h204, 32'h0, TO, 32'h33333333, 0);
    // Misaligned load.
    run_op(2'b01, 32'h102, 32'h0, 2, 32'h44444444, 0);
    idle_cycle();

    // Asynchronous reset in the middle of an access.
    mem_ctl_in = 2'b01; addr_in = 32'h300; dm_ack = 1'b0; adv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", dm_req, 1);
    #2 rst = 1'b1; mem_ctl_in = 2'b00;
    #1;
    chk("async_rst_req", dm_req, 0);
    chk("async_rst_stall", stall_out, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    dm_ack = 1'b1; dm_rdata = 32'h55555555;
    @(negedge clk);
    chk("late_ack_req", dm_req, 0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_stall", stall_out, 0);
    chk("late_ack_mem", mem_out, 0);
    chk("late_ack_err", err_out, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_op(2'($urandom_range(1, 3)), a, $urandom, $urandom_range(1, TO + 2),
             $urandom, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
